// File: rtl/fdsynch_bank.sv
// fdsynch_bank: CHANNELS independent WIDTH-bit registers, each loaded through a STAGES-deep synchroniser and a STABLE-sample filter (optional raw force-load under `FDSYNCH_BANK_FORCE_EN`).
// Latency: STAGES+STABLE clocks from a d/ld change to q (STAGES+1 when STABLE=1); frc loads at the next edge.
// Backpressure: none; inputs are sampled every cycle and q holds until the next qualifying load.
module fdsynch_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STAGES   = 2,
    parameter int STABLE   = 2
) (
    input  logic                      clk,
    input  logic                      resetl,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic [CHANNELS-1:0]       ld,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       upd,
    output logic [CHANNELS-1:0]       stab
`ifdef FDSYNCH_BANK_FORCE_EN
    ,
    input  logic [CHANNELS-1:0]       frc
`endif
);

    localparam int            CW      = $clog2(STABLE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("fdsynch_bank: STAGES must be in 1..4");
    end
    if (STABLE < 1 || STABLE > 15) begin : g_bad_stable
        $error("fdsynch_bank: STABLE must be in 1..15");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // ld and d share one synchroniser word so they can never skew apart
        logic [WIDTH:0]   sync_r [STAGES];
        logic [WIDTH-1:0] d_raw;
        logic [WIDTH-1:0] d_s;
        logic [WIDTH-1:0] prev_r;
        logic [WIDTH-1:0] q_r;
        logic             ld_s;
        logic             frc_c;
        logic             load;
        logic             upd_r;
        logic             stab_r;
        logic [CW-1:0]    cnt_r;
        logic [CW-1:0]    cnt_nxt;

        assign d_raw       = d[c*WIDTH +: WIDTH];
        assign {ld_s, d_s} = sync_r[STAGES-1];

`ifdef FDSYNCH_BANK_FORCE_EN
        assign frc_c = frc[c];
`else
        assign frc_c = 1'b0;
`endif

        always_comb begin
            cnt_nxt = cnt_r;
            if (d_s != prev_r) begin
                cnt_nxt = CNT_ONE;
            end else if (cnt_r != CNT_MAX) begin
                cnt_nxt = cnt_r + 1'b1;
            end
        end

        assign load = ld_s && (cnt_nxt == CNT_MAX);

        always_ff @(posedge clk) begin
            if (!resetl) begin
                for (int i = 0; i < STAGES; i++) begin
                    sync_r[i] <= '0;
                end
                prev_r <= '0;
                cnt_r  <= '0;
                q_r    <= '0;
                upd_r  <= 1'b0;
                stab_r <= 1'b0;
            end else begin
                sync_r[0] <= {ld[c], d_raw};
                for (int i = 1; i < STAGES; i++) begin
                    sync_r[i] <= sync_r[i-1];
                end
                prev_r <= d_s;
                // Force takes the raw input and restarts the filter from zero
                if (frc_c) begin
                    q_r    <= d_raw;
                    upd_r  <= (d_raw != q_r);
                    cnt_r  <= '0;
                    stab_r <= 1'b0;
                end else begin
                    cnt_r  <= cnt_nxt;
                    stab_r <= (cnt_nxt == CNT_MAX);
                    upd_r  <= load && (d_s != q_r);
                    if (load) begin
                        q_r <= d_s;
                    end
                end
            end
        end

        assign q[c*WIDTH +: WIDTH] = q_r;
        assign upd[c]              = upd_r;
        assign stab[c]             = stab_r;
    end

endmodule

// File: tb/tb_fdsynch_bank.sv
// Bench for fdsynch_bank: directed scenarios plus randomized traffic against a sample-history reference model.
module tb_fdsynch_bank;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int STAGES   = 2;
    localparam int STABLE   = 2;
    localparam int DW       = CHANNELS * WIDTH;

    logic                clk    = 1'b0;
    logic                resetl = 1'b0;
    logic [DW-1:0]       d      = '0;
    logic [CHANNELS-1:0] ld     = '0;
    logic [DW-1:0]       q;
    logic [CHANNELS-1:0] upd;
    logic [CHANNELS-1:0] stab;
`ifdef FDSYNCH_BANK_FORCE_EN
    logic [CHANNELS-1:0] frc = '0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fdsynch_bank #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .STAGES(STAGES), .STABLE(STABLE)
    ) dut (
        .clk    (clk),
        .resetl (resetl),
        .d      (d),
        .ld     (ld),
        .q      (q),
        .upd    (upd),
        .stab   (stab)
`ifdef FDSYNCH_BANK_FORCE_EN
        ,
        .frc    (frc)
`endif
    );

    // Reference model: a list of raw samples since reset; the synchronised value is simply
    // the sample taken STAGES edges earlier, and stability is the trailing run of equal
    // synchronised values (counted from reset or the last force on that channel).
    typedef struct packed {
        logic [DW-1:0]       dv;
        logic [CHANNELS-1:0] lv;
    } smp_t;

    smp_t                raw_q[$];
    logic [DW-1:0]       ds_q[$];
    int                  start_idx [CHANNELS];
    logic [DW-1:0]       m_q    = '0;
    logic [CHANNELS-1:0] m_upd  = '0;
    logic [CHANNELS-1:0] m_stab = '0;
    smp_t                m_cur;
    smp_t                m_syn;
    logic [WIDTH-1:0]    m_v;
    int                  m_run;

    always @(posedge clk) begin
        if (!resetl) begin
            raw_q.delete();
            ds_q.delete();
            for (int c = 0; c < CHANNELS; c++) start_idx[c] = 0;
            m_q    = '0;
            m_upd  = '0;
            m_stab = '0;
        end else begin
            m_cur.dv = d;
            m_cur.lv = ld;
            raw_q.push_back(m_cur);
            if (raw_q.size() > STAGES) m_syn = raw_q[raw_q.size() - 1 - STAGES];
            else                       m_syn = '0;
            ds_q.push_back(m_syn.dv);
            for (int c = 0; c < CHANNELS; c++) begin
                m_v   = m_syn.dv[c*WIDTH +: WIDTH];
                m_run = 0;
                for (int i = ds_q.size() - 1; i >= start_idx[c] && m_run < STABLE; i--) begin
                    if (ds_q[i][c*WIDTH +: WIDTH] == m_v) m_run++;
                    else break;
                end
                m_upd[c] = 1'b0;
`ifdef FDSYNCH_BANK_FORCE_EN
                if (frc[c]) begin
                    m_upd[c]  = (d[c*WIDTH +: WIDTH] != m_q[c*WIDTH +: WIDTH]);
                    m_q[c*WIDTH +: WIDTH] = d[c*WIDTH +: WIDTH];
                    m_stab[c] = 1'b0;
                    start_idx[c] = ds_q.size();
                    continue;
                end
`endif
                m_stab[c] = (m_run >= STABLE);
                if (m_syn.lv[c] && m_run >= STABLE) begin
                    m_upd[c] = (m_v != m_q[c*WIDTH +: WIDTH]);
                    m_q[c*WIDTH +: WIDTH] = m_v;
                end
            end
        end
    end

    function automatic logic [WIDTH-1:0] chq(input int c);
        return q[c*WIDTH +: WIDTH];
    endfunction

    task automatic set_d(input int c, input logic [WIDTH-1:0] v);
        d[c*WIDTH +: WIDTH] = v;
    endtask

    task automatic test_reset();
        logic [DW-1:0] exp_q;
        resetl = 1'b0;
        d      = '1;
        ld     = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if ({q, upd, stab} !== '0) $display("FAIL reset_hold k=%0d got q=%h upd=%b stab=%b want all zero", k, q, upd, stab);
            else n_pass++;
        end
        resetl = 1'b1;
        for (int k = 1; k <= STAGES + STABLE; k++) begin
            @(negedge clk);
            exp_q = (k == STAGES + STABLE) ? {DW{1'b1}} : {DW{1'b0}};
            n_total++;
            if (q !== exp_q) $display("FAIL reset_release_q k=%0d got %h want %h", k, q, exp_q);
            else n_pass++;
        end
        n_total++;
        if (upd !== {CHANNELS{1'b1}}) $display("FAIL reset_release_upd got %b want %b", upd, {CHANNELS{1'b1}});
        else n_pass++;
    endtask

    task automatic test_defaults();
        logic [WIDTH-1:0] exp0;
        set_d(0, 8'hA5);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp0 = (k >= 4) ? 8'hA5 : 8'hFF;
            n_total++;
            if (chq(0) !== exp0) $display("FAIL dflt_q0 k=%0d got %h want %h", k, chq(0), exp0);
            else n_pass++;
            n_total++;
            if (upd[0] !== (k == 4)) $display("FAIL dflt_upd0 k=%0d got %b want %b", k, upd[0], (k == 4));
            else n_pass++;
            n_total++;
            if (q[DW-1:WIDTH] !== {(DW-WIDTH){1'b1}}) $display("FAIL dflt_others k=%0d got %h", k, q[DW-1:WIDTH]);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        logic [WIDTH-1:0] exp1;
        for (int i = 0; i < 10; i++) begin
            set_d(1, (i % 2 == 0) ? 8'h34 : 8'h12);
            @(negedge clk);
            if (i >= 3) begin
                n_total++;
                if (chq(1) !== 8'hFF || stab[1] !== 1'b0)
                    $display("FAIL glitch_hold i=%0d got q1=%h stab1=%b want FF/0", i, chq(1), stab[1]);
                else n_pass++;
            end
        end
        set_d(1, 8'h34);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp1 = (k >= STAGES + STABLE) ? 8'h34 : 8'hFF;
            n_total++;
            if (chq(1) !== exp1) $display("FAIL glitch_settle k=%0d got %h want %h", k, chq(1), exp1);
            else n_pass++;
        end
    endtask

    task automatic test_load_gating();
        logic [WIDTH-1:0] exp2;
        ld[2] = 1'b0;
        set_d(2, 8'h5A);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_total++;
            if (chq(2) !== 8'hFF) $display("FAIL gate_hold k=%0d got %h want ff", k, chq(2));
            else n_pass++;
        end
        n_total++;
        if (stab[2] !== 1'b1) $display("FAIL gate_stab got %b want 1", stab[2]);
        else n_pass++;
        ld[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            ld[2] = 1'b0;
            exp2 = (k >= STAGES + 1) ? 8'h5A : 8'hFF;
            n_total++;
            if (chq(2) !== exp2) $display("FAIL gate_pulse k=%0d got %h want %h", k, chq(2), exp2);
            else n_pass++;
        end
    endtask

    task automatic test_same_value();
        logic [WIDTH-1:0] exp3;
        set_d(3, 8'h77);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp3 = (k >= 4) ? 8'h77 : 8'hFF;
            n_total++;
            if (chq(3) !== exp3 || upd[3] !== (k == 4))
                $display("FAIL same_val k=%0d got q3=%h upd3=%b want %h/%b", k, chq(3), upd[3], exp3, (k == 4));
            else n_pass++;
        end
        set_d(3, 8'h88);
        repeat (2) @(negedge clk);
        resetl = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if ({q, upd, stab} !== '0) $display("FAIL midcount_reset got q=%h upd=%b stab=%b want zero", q, upd, stab);
            else n_pass++;
        end
        resetl = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            exp3 = (k >= STAGES + STABLE) ? 8'h88 : 8'h00;
            n_total++;
            if (chq(3) !== exp3 || chq(2) !== 8'h00)
                $display("FAIL restart k=%0d got q3=%h q2=%h want %h/00", k, chq(3), chq(2), exp3);
            else n_pass++;
        end
    endtask

`ifdef FDSYNCH_BANK_FORCE_EN
    task automatic test_force();
        ld[0] = 1'b1;
        set_d(0, 8'h11);
        repeat (3) @(negedge clk);
        set_d(0, 8'h3C);
        frc[0] = 1'b1;
        @(negedge clk);
        frc[0] = 1'b0;
        n_total++;
        if (chq(0) !== 8'h3C || upd[0] !== 1'b1 || stab[0] !== 1'b0)
            $display("FAIL force got q0=%h upd0=%b stab0=%b want 3c/1/0", chq(0), upd[0], stab[0]);
        else n_pass++;
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            n_total++;
            if ({q, upd, stab} !== {m_q, m_upd, m_stab})
                $display("FAIL random k=%0d got q=%h upd=%b stab=%b want q=%h upd=%b stab=%b",
                         k, q, upd, stab, m_q, m_upd, m_stab);
            else n_pass++;
            resetl = ($urandom_range(0, 59) != 0);
            for (int c = 0; c < CHANNELS; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0) set_d(c, WIDTH'($urandom_range(0, 255)));
                    else                           set_d(c, WIDTH'($urandom_range(0, 2) * 8'h55));
                end
                ld[c] = ($urandom_range(0, 3) != 0);
`ifdef FDSYNCH_BANK_FORCE_EN
                frc[c] = ($urandom_range(0, 15) == 0);
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_glitch();
        test_load_gating();
        test_same_value();
`ifdef FDSYNCH_BANK_FORCE_EN
        test_force();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
